serial_addsub: RTL and testbench

Parametrised multi-digit serial adder/subtractor. It loads two WIDTH-bit operands on a start handshake and processes them DIGIT bits per clock, least-significant digit first. It then presents the sum or difference with carry and signed-overflow flags and a one-cycle done pulse. It supersedes the fixed 1-bit-per-cycle, add-only serial adder as the arithmetic engine for area-constrained datapaths.

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/serial_addsub_if.sv | 24 ++
 rtl/serial_digit_adder.sv | 18 +
 rtl/serial_addsub.sv | 111 +++++++++++
 tb/tb_serial_addsub.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Digit counter width; at least one bit even when a single digit is processed.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/response bundle of the serial adder/subtractor.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] I_A;
  logic [WIDTH-1:0] I_B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, mode, I_A, I_B,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, mode, I_A, I_B,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit adder with carry in/out.
module serial_digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);
  logic [DIGIT:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    sum  = full[DIGIT-1:0];
    cout = full[DIGIT];
  end
endmodule

// File: rtl/serial_addsub.sv
// Multi-digit serial adder/subtractor: LSD first, DIGIT bits per clock,
// registered result with carry/overflow flags and a one-cycle done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(N);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_addsub: WIDTH must be a multiple of DIGIT");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_addsub: WIDTH must be at least 2");
  end

  state_t                 state;
  logic [WIDTH-1:0]       a_sr;
  logic [WIDTH-1:0]       b_sr;
  logic [WIDTH-1:0]       res_sr;
  logic                   carry;
  logic                   a_sign;
  logic                   b_sign;
  logic [CW-1:0]          cnt;
  logic                   busy_r;
  logic                   done_r;
  logic                   carry_out_r;
  logic                   overflow_r;
  logic [DIGIT-1:0]       sum;
  logic                   cout;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;
  logic                   last;

  serial_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a   (a_sr[DIGIT-1:0]),
    .b   (b_sr[DIGIT-1:0]),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );

  // Concatenate-then-slice keeps the MSB-end shift legal when DIGIT == WIDTH.
  always_comb begin
    res_cat  = {sum, res_sr};
    res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
    last     = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      res_sr      <= '0;
      carry       <= 1'b0;
      a_sign      <= 1'b0;
      b_sign      <= 1'b0;
      cnt         <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_sr   <= bus.I_A;
            b_sr   <= bus.mode ? ~bus.I_B : bus.I_B;
            carry  <= bus.mode;
            cnt    <= '0;
            a_sign <= bus.I_A[WIDTH-1];
            b_sign <= bus.mode ? ~bus.I_B[WIDTH-1] : bus.I_B[WIDTH-1];
            busy_r <= 1'b1;
            state  <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          carry  <= cout;
          cnt    <= cnt + 1'b1;
          if (last) begin
            carry_out_r <= cout;
            overflow_r  <= (a_sign == b_sign) && (res_next[WIDTH-1] != a_sign);
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state       <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = res_sr;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: nine WIDTH/DIGIT variants driven from one stimulus process,
// checked by a forked monitor against a plain-arithmetic reference model.
module tb_serial_addsub;

  localparam int unsigned NI = 9;

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        ov;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        start_v [NI];
  logic        mode_v  [NI];
  logic [15:0] a_v     [NI];
  logic [15:0] b_v     [NI];
  logic        busy_v  [NI];
  logic        done_v  [NI];
  logic        co_v    [NI];
  logic        ov_v    [NI];
  logic [15:0] res_v   [NI];

  exp_t        exp_q   [NI][$];
  int          next_ok [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned W = (g / 3 == 0) ? 4 : (g / 3 == 1) ? 8 : 16;
    localparam int unsigned D = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 2 : 4;

    serial_addsub_if #(.WIDTH(W)) bus ();

    assign bus.start = start_v[g];
    assign bus.mode  = mode_v[g];
    assign bus.I_A   = a_v[g][W-1:0];
    assign bus.I_B   = b_v[g][W-1:0];
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign co_v[g]   = bus.carry_out;
    assign ov_v[g]   = bus.overflow;
    assign res_v[g]  = 16'(bus.result);

    serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  function automatic int wof(input int i);
    return (i / 3 == 0) ? 4 : (i / 3 == 1) ? 8 : 16;
  endfunction

  function automatic int nof(input int i);
    return wof(i) / ((i % 3 == 0) ? 1 : (i % 3 == 1) ? 2 : 4);
  endfunction

  // Reference: unsigned and signed integer arithmetic on the W-bit operands.
  function automatic exp_t model(input int i, input bit m, input logic [15:0] a,
                                 input logic [15:0] b, input int c);
    exp_t   e;
    longint span, ua, ub, sa, sb, ur, st;
    span  = longint'(1) << wof(i);
    ua    = longint'(a) % span;
    ub    = longint'(b) % span;
    sa    = (ua >= span / 2) ? ua - span : ua;
    sb    = (ub >= span / 2) ? ub - span : ub;
    ur    = m ? ua - ub : ua + ub;
    st    = m ? sa - sb : sa + sb;
    e.res = 16'(((ur % span) + span) % span);
    e.co  = m ? (ua >= ub) : (ur >= span);
    e.ov  = (st >= span / 2) || (st < -(span / 2));
    e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", name, i, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < NI; i++) begin
          if (done_v[i]) begin
            if (exp_q[i].size() == 0) begin
              chk("unexpected_done", i, 32'd1, 32'd0);
            end else begin
              e = exp_q[i].pop_front();
              chk("result", i, 32'(res_v[i]), 32'(e.res));
              chk("carry_out", i, 32'(co_v[i]), 32'(e.co));
              chk("overflow", i, 32'(ov_v[i]), 32'(e.ov));
              chk("done_cycle", i, 32'(cyc), 32'(e.cyc));
              chk("busy_at_done", i, 32'(busy_v[i]), 32'd0);
            end
          end
        end
      end
    end
  endtask

  // Called right after a negedge; start is sampled at the following posedge.
  task automatic go(input int i, input bit m, input logic [15:0] a, input logic [15:0] b,
                    input bit fixed, input logic [15:0] er, input bit ec, input bit eo);
    exp_t e;
    bit   acc;
    start_v[i] = 1'b1;
    mode_v[i]  = m;
    a_v[i]     = a;
    b_v[i]     = b;
    acc = (cyc >= next_ok[i]);
    if (acc) begin
      e = model(i, m, a, b, cyc + 1 + nof(i));
      if (fixed) begin
        e.res = er;
        e.co  = ec;
        e.ov  = eo;
      end
      exp_q[i].push_back(e);
      next_ok[i] = cyc + 1 + nof(i);
    end
    @(negedge clk);
    start_v[i] = 1'b0;
    mode_v[i]  = 1'($urandom);
    a_v[i]     = 16'($urandom);
    b_v[i]     = 16'($urandom);
    if (acc) chk("busy_after_start", i, 32'(busy_v[i]), 32'd1);
  endtask

  task automatic wait_free(input int i);
    while (cyc <= next_ok[i]) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag, input int i);
    chk({tag, "_busy"}, i, 32'(busy_v[i]), 32'd0);
    chk({tag, "_done"}, i, 32'(done_v[i]), 32'd0);
    chk({tag, "_result"}, i, 32'(res_v[i]), 32'd0);
    chk({tag, "_carry"}, i, 32'(co_v[i]), 32'd0);
    chk({tag, "_ovf"}, i, 32'(ov_v[i]), 32'd0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000 >> (16 - $urandom_range(4, 16));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 1'b0;
      a_v[i]     = '0;
      b_v[i]     = '0;
      next_ok[i] = 0;
    end
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) chk_zero("reset", i);
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=4 DIGIT=1
    go(0, 1'b0, 16'd4, 16'd6, 1'b1, 16'hA, 1'b0, 1'b1);
    wait_free(0);
    go(0, 1'b0, 16'd14, 16'd7, 1'b1, 16'h5, 1'b1, 1'b0);
    go(0, 1'b1, 16'd3, 16'd1, 1'b0, '0, 1'b0, 1'b0);
    wait_free(0);
    go(0, 1'b1, 16'd9, 16'd6, 1'b1, 16'h3, 1'b1, 1'b1);
    while (cyc < next_ok[0]) @(negedge clk);
    go(0, 1'b1, 16'd6, 16'd9, 1'b1, 16'hD, 1'b0, 1'b1);
    wait_free(0);

    // WIDTH=8 DIGIT=4
    go(5, 1'b0, 16'hFF, 16'h01, 1'b1, 16'h00, 1'b1, 1'b0);
    wait_free(5);
    go(5, 1'b0, 16'h7F, 16'h01, 1'b1, 16'h80, 1'b0, 1'b1);
    wait_free(5);

    // Asynchronous reset in the middle of an operation
    go(0, 1'b0, 16'd5, 16'd5, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    exp_q[0].delete();
    for (int i = 0; i < NI; i++) next_ok[i] = 0;
    #1 chk_zero("midrun_reset", 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    go(0, 1'b0, 16'd3, 16'd2, 1'b1, 16'h5, 1'b0, 1'b0);
    wait_free(0);

    // Random sweep; short gaps deliberately land starts inside RUN
    for (int i = 0; i < NI; i++) begin
      for (int t = 0; t < 30; t++) begin
        go(i, 1'($urandom), pick(), pick(), 1'b0, '0, 1'b0, 1'b0);
        repeat ($urandom_range(0, nof(i) + 2)) @(negedge clk);
      end
      wait_free(i);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) chk("pending_done", i, 32'(exp_q[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
